// File: rtl/ysyx_22040632_arb_pkg.sv
// Shared types and default widths for the IFU/LSU memory arbiter.
// The round-robin option is selected with YSYX_22040632_ARB_RR_EN (see the top module).
package ysyx_22040632_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 64;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ysyx_22040632_arb_pick.sv
// Combinational 2-way request picker: fixed LSU priority, or round-robin on
// last_grant when RR_EN is set. Kept separate so other port splits can reuse it.
module ysyx_22040632_arb_pick
    import ysyx_22040632_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    input  owner_t last_grant,
    output logic   grant_valid,
    output owner_t grant
);

    always_comb begin
        grant_valid = ifu_valid | lsu_valid;
        grant       = OWN_LSU;
        if (ifu_valid && !lsu_valid) begin
            grant = OWN_IFU;
        end else if (ifu_valid && lsu_valid && RR_EN && (last_grant == OWN_LSU)) begin
            // On contention, round-robin hands the bus to whoever did not win last.
            grant = OWN_IFU;
        end
    end

endmodule

// File: rtl/ysyx_22040632_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU.
// Define YSYX_22040632_ARB_RR_EN for round-robin arbitration instead of fixed LSU priority.
module ysyx_22040632_mem_arbiter
    import ysyx_22040632_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    input  logic              ifu_flush,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_resp_data,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [STRB_W-1:0] lsu_req_wstrb,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [STRB_W-1:0] mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              busy
);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;

    logic              grant_valid;
    owner_t            grant;
    owner_t            last_grant_q;

`ifdef YSYX_22040632_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
    owner_t last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if ((state_q == ARB_IDLE) && grant_valid) begin
            last_grant_d = grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= OWN_IFU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    localparam bit RR_EN = 1'b0;
    assign last_grant_q = OWN_IFU;
`endif

    ysyx_22040632_arb_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .ifu_valid   (ifu_req_valid),
        .lsu_valid   (lsu_req_valid),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        drop_d        = drop_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_d = ARB_REQ;
                    owner_d = grant;
                    if (grant == OWN_LSU) begin
                        lsu_req_ready = 1'b1;
                        addr_d        = lsu_req_addr;
                        wen_d         = lsu_req_wen;
                        wdata_d       = lsu_req_wdata;
                        wstrb_d       = lsu_req_wstrb;
                        drop_d        = 1'b0;
                    end else begin
                        // Fetches are reads; store fields are cleared so the bus sees clean values.
                        ifu_req_ready = 1'b1;
                        addr_d        = ifu_req_addr;
                        wen_d         = 1'b0;
                        wdata_d       = '0;
                        wstrb_d       = '0;
                        drop_d        = ifu_flush;
                    end
                end
            end
            ARB_REQ: begin
                if ((owner_q == OWN_IFU) && ifu_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_req_ready) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if ((owner_q == OWN_IFU) && ifu_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_resp_valid) begin
                    state_d = ARB_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IFU;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    logic resp_fire;
    assign resp_fire = (state_q == ARB_RESP) && mem_resp_valid;

    // Response data is zeroed whenever its valid is low, including dropped fetches.
    assign ifu_resp_valid = resp_fire && (owner_q == OWN_IFU) && !drop_q;
    assign lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
    assign ifu_resp_data  = ifu_resp_valid ? mem_resp_data : '0;
    assign lsu_resp_data  = lsu_resp_valid ? mem_resp_data : '0;

    assign mem_req_valid = (state_q == ARB_REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;
    assign busy          = (state_q != ARB_IDLE);

`ifndef SYNTHESIS
    resp_only_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
        mem_resp_valid |-> (state_q == ARB_RESP));
`endif

endmodule

// File: tb/tb_ysyx_22040632_mem_arbiter.sv
// Directed + randomized bench for ysyx_22040632_mem_arbiter with a transaction-level model.
// Expectations follow YSYX_22040632_ARB_RR_EN when the design is built with it.
module tb_ysyx_22040632_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_flush, ifu_resp_valid;
    logic [31:0] ifu_req_addr;
    logic [63:0] ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
    logic [31:0] lsu_req_addr;
    logic [63:0] lsu_req_wdata, lsu_resp_data;
    logic [7:0]  lsu_req_wstrb;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, busy;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata, mem_resp_data;
    logic [7:0]  mem_req_wstrb;

    int n_tests = 0;
    int n_fail  = 0;
    bit m_last  = 1'b0;   // model: last winner, 0 = IFU, 1 = LSU
`ifdef YSYX_22040632_ARB_RR_EN
    bit rr = 1'b1;
`else
    bit rr = 1'b0;
`endif

    always #5 clk = ~clk;

    ysyx_22040632_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_flush(ifu_flush),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ifu_ready"}, ifu_req_ready, 0);
        check({tag, ".lsu_ready"}, lsu_req_ready, 0);
        check({tag, ".ifu_rvalid"}, ifu_resp_valid, 0);
        check({tag, ".lsu_rvalid"}, lsu_resp_valid, 0);
        check({tag, ".mem_valid"}, mem_req_valid, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".mem_addr"}, mem_req_addr, 0);
        check({tag, ".mem_wstrb"}, mem_req_wstrb, 0);
    endtask

    // One complete transaction, entered and left in an IDLE cycle (1 ns after the edge).
    // flush_cyc: -1 none, 0 = accept cycle, k = k-th busy cycle before the response.
    task automatic run_txn(input string tag, input bit iv, input bit lv,
                           input logic [31:0] ia, input logic [31:0] la, input bit lwen,
                           input logic [63:0] lwd, input logic [7:0] lws,
                           input int stall, input int delay, input int flush_cyc,
                           input logic [63:0] rdata);
        bit w;
        bit drop;
        int cyc;
        logic [31:0] ea;
        logic [63:0] ewd;
        logic [7:0]  ews;
        bit          ewen;
        if (iv && !lv)      w = 1'b0;
        else if (!iv && lv) w = 1'b1;
        else                w = rr ? ~m_last : 1'b1;
        ea   = w ? la : ia;
        ewen = w ? lwen : 1'b0;
        ewd  = w ? lwd : 64'd0;
        ews  = w ? lws : 8'd0;
        drop = !w && (flush_cyc >= 0);

        ifu_req_valid = iv; ifu_req_addr = ia;
        lsu_req_valid = lv; lsu_req_addr = la; lsu_req_wen = lwen;
        lsu_req_wdata = lwd; lsu_req_wstrb = lws;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        ifu_flush = (flush_cyc == 0);
        #1;
        check({tag, ".acc_ifu_ready"}, ifu_req_ready, !w);
        check({tag, ".acc_lsu_ready"}, lsu_req_ready, w);
        check({tag, ".acc_mem_valid"}, mem_req_valid, 0);
        step();
        // Winner withdraws and scrambles its fields; the loser keeps requesting.
        if (w) begin
            lsu_req_valid = 1'b0; lsu_req_addr = $urandom; lsu_req_wen = ~lwen;
            lsu_req_wdata = {$urandom, $urandom}; lsu_req_wstrb = 8'($urandom);
        end else begin
            ifu_req_valid = 1'b0; ifu_req_addr = $urandom;
        end
        cyc = 1;
        for (int i = 0; i <= stall; i++) begin
            mem_req_ready = (i == stall);
            ifu_flush = (cyc == flush_cyc);
            #1;
            check({tag, ".req_valid"}, mem_req_valid, 1);
            check({tag, ".req_addr"}, mem_req_addr, ea);
            check({tag, ".req_wen"}, mem_req_wen, ewen);
            check({tag, ".req_wdata"}, mem_req_wdata, ewd);
            check({tag, ".req_wstrb"}, mem_req_wstrb, ews);
            check({tag, ".req_readies"}, {ifu_req_ready, lsu_req_ready}, 0);
            check({tag, ".req_busy"}, busy, 1);
            step();
            cyc++;
        end
        mem_req_ready = 1'b0;
        for (int d = 0; d < delay; d++) begin
            ifu_flush = (cyc == flush_cyc);
            #1;
            check({tag, ".wait_mem_valid"}, mem_req_valid, 0);
            check({tag, ".wait_rvalids"}, {ifu_resp_valid, lsu_resp_valid}, 0);
            check({tag, ".wait_readies"}, {ifu_req_ready, lsu_req_ready}, 0);
            check({tag, ".wait_busy"}, busy, 1);
            step();
            cyc++;
        end
        ifu_flush = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = rdata;
        #1;
        check({tag, ".ifu_rvalid"}, ifu_resp_valid, !w && !drop);
        check({tag, ".lsu_rvalid"}, lsu_resp_valid, w);
        check({tag, ".ifu_rdata"}, ifu_resp_data, (!w && !drop) ? rdata : 64'd0);
        check({tag, ".lsu_rdata"}, lsu_resp_data, w ? rdata : 64'd0);
        check({tag, ".resp_readies"}, {ifu_req_ready, lsu_req_ready}, 0);
        step();
        mem_resp_valid = 1'b0;
        mem_resp_data = 64'd0;
        #1;
        check({tag, ".end_busy"}, busy, 0);
        check({tag, ".end_mem_valid"}, mem_req_valid, 0);
        m_last = w;
        $display("[TB] %s: winner=%s addr=0x%08h stall=%0d delay=%0d flush=%0d", tag,
                 w ? "LSU" : "IFU", ea, stall, delay, flush_cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ifu_req_valid = 0; ifu_req_addr = 0; ifu_flush = 0;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0;
        lsu_req_wdata = 0; lsu_req_wstrb = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        run_txn("ifu_alone", 1, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 2, -1, 64'h1234);
        run_txn("both_1", 1, 1, 32'h8000_0040, 32'h8000_0100, 1, 64'hAA, 8'h01,
                0, 1, -1, 64'h55);
        run_txn("both_2", 1, 1, 32'h8000_0040, 32'h8000_0108, 0, 64'h0, 8'h00,
                0, 1, -1, 64'h66);
        run_txn("ifu_after", 1, 0, 32'h8000_0044, 0, 0, 0, 0, 0, 0, -1, 64'h77);
        run_txn("stall5", 1, 1, 32'h8000_0048, 32'h8000_0200, 0, 64'h0, 8'h00,
                5, 1, -1, 64'h0123_4567_89AB_CDEF);
        run_txn("flush_resp", 1, 0, 32'h8000_0050, 0, 0, 0, 0, 0, 3, 2, 64'hDEAD);
        run_txn("post_flush", 1, 0, 32'h8000_0054, 0, 0, 0, 0, 0, 1, -1, 64'hBEEF);
        run_txn("flush_acc", 1, 0, 32'h8000_0058, 0, 0, 0, 0, 1, 1, 0, 64'hF00D);
        run_txn("lsu_flush", 0, 1, 0, 32'h8000_0300, 0, 0, 0, 1, 2, 1, 64'hCAFE);

        for (int t = 0; t < 40; t++) begin
            int s, d, f, sel;
            bit iv, lv;
            sel = $urandom_range(1, 3);
            iv = sel[0];
            lv = sel[1];
            s = $urandom_range(0, 3);
            d = $urandom_range(0, 3);
            f = ($urandom_range(0, 2) == 0) ? $urandom_range(0, s + d) : -1;
            run_txn($sformatf("rand%0d", t), iv, lv, $urandom, $urandom, 1'($urandom),
                    {$urandom, $urandom}, 8'($urandom), s, d, f, {$urandom, $urandom});
        end

        // Asynchronous reset in the middle of a REQ phase.
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b0; ifu_req_addr = 32'h8000_0abc;
        #1;
        check("mid_rst.accept", ifu_req_ready, 1);
        step();
        ifu_req_valid = 1'b0;
        #1;
        check("mid_rst.req_valid", mem_req_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        $display("[TB] mid_rst: reset asserted during REQ");
        step();
        rst_n = 1'b1;
        m_last = 1'b0;
        step();
        run_txn("after_rst", 1, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 1, -1, 64'h4242);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
